// File: rtl/vip_stream_switch_nxm.sv
// NxM Avalon-ST video switch with Avalon-MM routing control.
// Route changes are applied only between packets; each output has a 2-entry skid buffer.
// Optional build macro: VIP_SWI_DROP_UNSELECTED_EN (unowned inputs accept and discard beats).
module vip_stream_switch_nxm #(
  parameter int unsigned NUM_INPUTS       = 4,
  parameter int unsigned NUM_OUTPUTS      = 2,
  parameter int unsigned DATA_WIDTH       = 24,
  parameter int unsigned AV_ADDRESS_WIDTH = 5
) (
  input  logic                              clock,
  input  logic                              reset,
  output logic [NUM_INPUTS-1:0]             din_ready,
  input  logic [NUM_INPUTS-1:0]             din_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  din_data,
  input  logic [NUM_INPUTS-1:0]             din_startofpacket,
  input  logic [NUM_INPUTS-1:0]             din_endofpacket,
  input  logic [NUM_OUTPUTS-1:0]            dout_ready,
  output logic [NUM_OUTPUTS-1:0]            dout_valid,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] dout_data,
  output logic [NUM_OUTPUTS-1:0]            dout_startofpacket,
  output logic [NUM_OUTPUTS-1:0]            dout_endofpacket,
  input  logic [AV_ADDRESS_WIDTH-1:0]       control_address,
  input  logic                              control_read,
  output logic [31:0]                       control_readdata,
  input  logic                              control_write,
  input  logic [31:0]                       control_writedata
);

  typedef enum logic [1:0] {StIdle, StRouted, StInPkt} state_e;

  state_e                  state_q    [NUM_OUTPUTS];
  logic [3:0]              pend_sel_q [NUM_OUTPUTS];
  logic [3:0]              req_sel_q  [NUM_OUTPUTS];
  logic [3:0]              act_sel_q  [NUM_OUTPUTS];
  logic [3:0]              eff_sel    [NUM_OUTPUTS];
  logic                    go_q;
  logic [31:0]             rdata;

  logic [NUM_OUTPUTS-1:0]  owned_by   [NUM_INPUTS];
  logic [NUM_INPUTS-1:0]   claimed;
  logic [NUM_OUTPUTS-1:0]  in_valid, in_sop, in_eop, push, pop, full;
  logic [DATA_WIDTH-1:0]   in_data    [NUM_OUTPUTS];

  logic [DATA_WIDTH-1:0]   buf_data_q [NUM_OUTPUTS][2];
  logic [1:0]              buf_sop_q  [NUM_OUTPUTS];
  logic [1:0]              buf_eop_q  [NUM_OUTPUTS];
  logic [1:0]              cnt_q      [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0]  wptr_q, rptr_q;

  logic unused_wdata;
  assign unused_wdata = ^control_writedata[31:4];

  // Select k routes input k-1; zero or anything past NUM_INPUTS disables the output.
  function automatic logic sel_ok(input logic [3:0] s);
    return (s != 4'd0) && (32'(s) <= NUM_INPUTS);
  endfunction

  // Effective source per output: locked while in a packet, follows the request between packets.
  always_comb begin
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      eff_sel[j] = 4'd0;
      if (state_q[j] == StInPkt) begin
        eff_sel[j] = act_sel_q[j];
      end else if (state_q[j] == StRouted && go_q && sel_ok(req_sel_q[j])) begin
        eff_sel[j] = req_sel_q[j];
      end
    end
  end

  // Input ownership: an output mid-packet keeps its source, otherwise the lowest index wins.
  always_comb begin
    claimed = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      owned_by[i] = '0;
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        if (!claimed[i] && state_q[j] == StInPkt && eff_sel[j] == 4'(i + 1)) begin
          owned_by[i][j] = 1'b1;
          claimed[i]     = 1'b1;
        end
      end
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        if (!claimed[i] && eff_sel[j] == 4'(i + 1)) begin
          owned_by[i][j] = 1'b1;
          claimed[i]     = 1'b1;
        end
      end
    end
  end

  // Data path muxing, input handshake and skid-buffer push/pop.
  always_comb begin
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      full[j]     = (cnt_q[j] == 2'd2);
      in_valid[j] = 1'b0;
      in_sop[j]   = 1'b0;
      in_eop[j]   = 1'b0;
      in_data[j]  = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (owned_by[i][j]) begin
          in_valid[j] = din_valid[i];
          in_sop[j]   = din_startofpacket[i];
          in_eop[j]   = din_endofpacket[i];
          in_data[j]  = din_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      push[j]               = in_valid[j] & ~full[j];
      dout_valid[j]         = (cnt_q[j] != 2'd0);
      pop[j]                = dout_valid[j] & dout_ready[j];
      dout_data[j*DATA_WIDTH +: DATA_WIDTH] = buf_data_q[j][rptr_q[j]];
      dout_startofpacket[j] = buf_sop_q[j][rptr_q[j]] & dout_valid[j];
      dout_endofpacket[j]   = buf_eop_q[j][rptr_q[j]] & dout_valid[j];
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
`ifdef VIP_SWI_DROP_UNSELECTED_EN
      din_ready[i] = ~reset;
`else
      din_ready[i] = 1'b0;
`endif
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        if (owned_by[i][j]) din_ready[i] = ~full[j];
      end
    end
  end

  // Per-output routing FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        state_q[j]   <= StIdle;
        act_sel_q[j] <= 4'd0;
      end
    end else begin
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        unique case (state_q[j])
          StIdle: begin
            if (go_q && sel_ok(req_sel_q[j])) begin
              state_q[j]   <= StRouted;
              act_sel_q[j] <= req_sel_q[j];
            end
          end
          StRouted: begin
            if (!go_q || !sel_ok(req_sel_q[j])) begin
              state_q[j]   <= StIdle;
              act_sel_q[j] <= 4'd0;
            end else begin
              act_sel_q[j] <= req_sel_q[j];
              if (push[j] && !in_eop[j]) state_q[j] <= StInPkt;
            end
          end
          StInPkt: begin
            if (push[j] && in_eop[j]) state_q[j] <= StRouted;
          end
          default: state_q[j] <= StIdle;
        endcase
      end
    end
  end

  // Per-output 2-entry skid buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        cnt_q[j]         <= 2'd0;
        buf_sop_q[j]     <= 2'b00;
        buf_eop_q[j]     <= 2'b00;
        buf_data_q[j][0] <= '0;
        buf_data_q[j][1] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        if (push[j]) begin
          buf_data_q[j][wptr_q[j]] <= in_data[j];
          buf_sop_q[j][wptr_q[j]]  <= in_sop[j];
          buf_eop_q[j][wptr_q[j]]  <= in_eop[j];
          wptr_q[j]                <= ~wptr_q[j];
        end
        if (pop[j]) rptr_q[j] <= ~rptr_q[j];
        case ({push[j], pop[j]})
          2'b10:   cnt_q[j] <= cnt_q[j] + 2'd1;
          2'b01:   cnt_q[j] <= cnt_q[j] - 2'd1;
          default: cnt_q[j] <= cnt_q[j];
        endcase
      end
    end
  end

  // Register read mux.
  always_comb begin
    rdata = 32'd0;
    if (32'(control_address) == 32'd0) rdata[0] = go_q;
    if (32'(control_address) == 32'd1) begin
      for (int j = 0; j < NUM_OUTPUTS; j++) rdata[j] = (state_q[j] == StInPkt);
    end
    for (int j = 0; j < NUM_OUTPUTS; j++) begin
      if (32'(control_address) == 32'(4 + j)) rdata[3:0] = pend_sel_q[j];
    end
  end

  // Control registers and registered read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      go_q             <= 1'b0;
      control_readdata <= 32'd0;
      for (int j = 0; j < NUM_OUTPUTS; j++) begin
        pend_sel_q[j] <= 4'd0;
        req_sel_q[j]  <= 4'd0;
      end
    end else begin
      control_readdata <= control_read ? rdata : 32'd0;
      if (control_write) begin
        if (32'(control_address) == 32'd0) go_q <= control_writedata[0];
        for (int j = 0; j < NUM_OUTPUTS; j++) begin
          if (32'(control_address) == 32'd2)     req_sel_q[j]  <= pend_sel_q[j];
          if (32'(control_address) == 32'(4 + j)) pend_sel_q[j] <= control_writedata[3:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_vip_stream_switch_nxm.sv
// Directed bench for vip_stream_switch_nxm (default 4x2, 24-bit pixels).
module tb_vip_stream_switch_nxm;
  localparam int NI = 4;
  localparam int NO = 2;
  localparam int DW = 24;
`ifdef VIP_SWI_DROP_UNSELECTED_EN
  localparam logic DropEn = 1'b1;
`else
  localparam logic DropEn = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [NI-1:0]     din_ready, din_valid, din_sop, din_eop;
  logic [NI*DW-1:0]  din_data;
  logic [NO-1:0]     dout_ready, dout_valid, dout_sop, dout_eop;
  logic [NO*DW-1:0]  dout_data;
  logic [4:0]        control_address;
  logic              control_read, control_write;
  logic [31:0]       control_readdata, control_writedata;

  int checks = 0;
  int failures = 0;
  logic [31:0] rv;

  always #5 clock = ~clock;

  vip_stream_switch_nxm dut (
    .clock              (clock),
    .reset              (reset),
    .din_ready          (din_ready),
    .din_valid          (din_valid),
    .din_data           (din_data),
    .din_startofpacket  (din_sop),
    .din_endofpacket    (din_eop),
    .dout_ready         (dout_ready),
    .dout_valid         (dout_valid),
    .dout_data          (dout_data),
    .dout_startofpacket (dout_sop),
    .dout_endofpacket   (dout_eop),
    .control_address    (control_address),
    .control_read       (control_read),
    .control_readdata   (control_readdata),
    .control_write      (control_write),
    .control_writedata  (control_writedata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    control_address = a; control_writedata = d; control_write = 1'b1;
    step();
    control_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    control_address = a; control_read = 1'b1;
    step();
    control_read = 1'b0;
    d = control_readdata;
  endtask

  task automatic drive(input int i, input logic v, input logic [DW-1:0] d,
                       input logic s, input logic e);
    din_valid[i] = v;
    din_data[i*DW +: DW] = d;
    din_sop[i] = s;
    din_eop[i] = e;
  endtask

  function automatic logic [31:0] dd(input int j);
    return {8'h00, dout_data[j*DW +: DW]};
  endfunction

  initial begin
    reset = 1'b1;
    din_valid = '0; din_sop = '0; din_eop = '0; din_data = '0;
    dout_ready = '1;
    control_address = '0; control_read = 1'b0; control_write = 1'b0;
    control_writedata = '0;
    repeat (3) step();
    chk("reset_dout_valid", {30'd0, dout_valid}, 32'd0);
    chk("reset_din_ready", {28'd0, din_ready}, 32'd0);
    chk("reset_readdata", control_readdata, 32'd0);
    reset = 1'b0;
    step();
    rd(5'd0, rv); chk("rst_ctrl", rv, 32'd0);
    rd(5'd4, rv); chk("rst_sel0", rv, 32'd0);

    // Basic route: out0 <- in1.
    wr(5'd4, 32'd2);
    wr(5'd2, 32'd0);
    wr(5'd0, 32'd1);
    step();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 1'b1, DW'(k), k == 1, k == 4);
      chk("basic_ready1", {31'd0, din_ready[1]}, 32'd1);
      chk("basic_ready0", {31'd0, din_ready[0]}, {31'd0, DropEn});
      step();
      chk("basic_valid", {31'd0, dout_valid[0]}, 32'd1);
      chk("basic_data", dd(0), k);
      chk("basic_sopeop", {30'd0, dout_sop[0], dout_eop[0]}, {30'd0, k == 1, k == 4});
    end
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    step();
    chk("basic_drain", {31'd0, dout_valid[0]}, 32'd0);

    // Boundary switch: out0 <- in0, then retarget to in2 mid-packet.
    wr(5'd4, 32'd1);
    wr(5'd2, 32'd0);
    drive(0, 1'b1, 24'h10, 1'b1, 1'b0);
    step();
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    chk("bnd_beat0", dd(0), 32'h10);
    rd(5'd1, rv); chk("bnd_status_inpkt", rv, 32'd1);
    wr(5'd4, 32'd3);
    wr(5'd2, 32'd0);
    drive(2, 1'b1, 24'h30, 1'b1, 1'b1);
    chk("bnd_in2_blocked", {31'd0, din_ready[2]}, {31'd0, DropEn});
    drive(0, 1'b1, 24'h11, 1'b0, 1'b0);
    step();
    chk("bnd_beat1", dd(0), 32'h11);
    drive(0, 1'b1, 24'h12, 1'b0, 1'b1);
    step();
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    chk("bnd_beat2", dd(0), 32'h12);
    chk("bnd_eop", {31'd0, dout_eop[0]}, 32'd1);
    chk("bnd_in2_ready", {31'd0, din_ready[2]}, 32'd1);
    step();
    drive(2, 1'b0, '0, 1'b0, 1'b0);
    chk("bnd_in2_data", dd(0), 32'h30);
    rd(5'd1, rv); chk("bnd_status_idle", rv, 32'd0);

    // Backpressure: out1 <- in3 with dout_ready[1] low.
    wr(5'd5, 32'd4);
    wr(5'd2, 32'd0);
    step();
    dout_ready[1] = 1'b0;
    drive(3, 1'b1, 24'h40, 1'b1, 1'b0);
    chk("bp_ready_a", {31'd0, din_ready[3]}, 32'd1);
    step();
    drive(3, 1'b1, 24'h41, 1'b0, 1'b0);
    chk("bp_ready_b", {31'd0, din_ready[3]}, 32'd1);
    step();
    drive(3, 1'b1, 24'h42, 1'b0, 1'b1);
    chk("bp_full", {31'd0, din_ready[3]}, 32'd0);
    step();
    chk("bp_still_full", {31'd0, din_ready[3]}, 32'd0);
    chk("bp_hold_data", dd(1), 32'h40);
    dout_ready[1] = 1'b1;
    step();
    chk("bp_out_b", dd(1), 32'h41);
    step();
    drive(3, 1'b0, '0, 1'b0, 1'b0);
    chk("bp_out_c", dd(1), 32'h42);
    step();
    chk("bp_empty", {31'd0, dout_valid[1]}, 32'd0);

    // Conflict: both outputs select in0; out0 owns it.
    wr(5'd4, 32'd1);
    wr(5'd5, 32'd1);
    wr(5'd2, 32'd0);
    drive(0, 1'b1, 24'h50, 1'b1, 1'b1);
    chk("cf_ready", {31'd0, din_ready[0]}, 32'd1);
    step();
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    chk("cf_out0", dd(0), 32'h50);
    chk("cf_out1_idle", {31'd0, dout_valid[1]}, 32'd0);
    wr(5'd4, 32'd2);
    wr(5'd2, 32'd0);
    drive(0, 1'b1, 24'h51, 1'b1, 1'b1);
    step();
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    chk("cf_out1_valid", {31'd0, dout_valid[1]}, 32'd1);
    chk("cf_out1_data", dd(1), 32'h51);
    chk("cf_out0_quiet", {31'd0, dout_valid[0]}, 32'd0);

    // Out-of-range select disables out0; readback keeps low nibble.
    wr(5'd4, 32'h1F);
    wr(5'd2, 32'd0);
    rd(5'd4, rv); chk("sel_readback", rv, 32'hF);
    rd(5'd2, rv); chk("commit_reads0", rv, 32'd0);
    rd(5'd3, rv); chk("unmapped", rv, 32'd0);
    drive(1, 1'b1, 24'h77, 1'b1, 1'b1);
    chk("drop_ready1", {31'd0, din_ready[1]}, {31'd0, DropEn});
    step();
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    chk("drop_no_out", {30'd0, dout_valid}, 32'd0);

    // Reset mid-packet on out1 <- in0.
    drive(0, 1'b1, 24'h60, 1'b1, 1'b0);
    step();
    drive(0, 1'b1, 24'h61, 1'b0, 1'b0);
    dout_ready[1] = 1'b0;
    chk("mid_valid", {31'd0, dout_valid[1]}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {30'd0, dout_valid}, 32'd0);
    chk("mid_rst_ready", {28'd0, din_ready}, 32'd0);
    step();
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    dout_ready = '1;
    reset = 1'b0;
    rd(5'd0, rv); chk("post_ctrl", rv, 32'd0);
    rd(5'd5, rv); chk("post_sel1", rv, 32'd0);
    rd(5'd1, rv); chk("post_status", rv, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
